// File: rtl/blood_infer.sv
// ============================================================================
// blood_infer : ranks the four possible unknown-parent ABO types for a child
// Rev 1.0
// ============================================================================
`default_nettype none

module blood_infer #(
  parameter int PROB_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        known_parent,
  input  logic [1:0]        child,
  output logic              busy,
  output logic              done,
  output logic [3:0]        cand_mask,
  output logic [PROB_W-1:0] prob_o,
  output logic [PROB_W-1:0] prob_b,
  output logic [PROB_W-1:0] prob_a,
  output logic [PROB_W-1:0] prob_ab,
  output logic [1:0]        best_type,
  output logic [PROB_W-1:0] best_prob,
  output logic              none
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               kp_q, kp_d;
  logic [1:0]               ch_q, ch_d;
  logic [1:0]               idx_q, idx_d;
  logic [3:0]               mask_q, mask_d;
  logic [3:0][PROB_W-1:0]   prob_q, prob_d;
  logic [1:0]               best_type_q, best_type_d;
  logic [PROB_W-1:0]        best_prob_q, best_prob_d;
  logic                     none_q, none_d;
  logic [PROB_W-1:0]        w_num;

  // Allele weights out of 4, packed as {a, b, o}.
  function automatic logic [3*PROB_W-1:0] weights(input logic [1:0] t);
    logic [3*PROB_W-1:0] r;
    case (t)
      2'b11:   r = {PROB_W'(2), PROB_W'(2), PROB_W'(0)};
      2'b10:   r = {PROB_W'(3), PROB_W'(0), PROB_W'(1)};
      2'b01:   r = {PROB_W'(0), PROB_W'(3), PROB_W'(1)};
      default: r = {PROB_W'(0), PROB_W'(0), PROB_W'(4)};
    endcase
    return r;
  endfunction

  function automatic logic [PROB_W-1:0] child_num(input logic [1:0] p,
                                                  input logic [1:0] q,
                                                  input logic [1:0] c);
    logic [PROB_W-1:0] ap, bp, op, aq, bq, oq, r;
    {ap, bp, op} = weights(p);
    {aq, bq, oq} = weights(q);
    case (c)
      2'b11:   r = ap * bq + bp * aq;
      2'b10:   r = ap * aq + ap * oq + op * aq;
      2'b01:   r = bp * bq + bp * oq + op * bq;
      default: r = op * oq;
    endcase
    return r;
  endfunction

  assign w_num = child_num(kp_q, idx_q, ch_q);

  always_comb begin
    state_d     = state_q;
    kp_d        = kp_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    mask_d      = mask_q;
    prob_d      = prob_q;
    best_type_d = best_type_q;
    best_prob_d = best_prob_q;
    none_d      = none_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          kp_d        = known_parent;
          ch_d        = child;
          idx_d       = 2'd0;
          mask_d      = 4'd0;
          prob_d      = '0;
          best_type_d = 2'd0;
          best_prob_d = '0;
          none_d      = 1'b0;
          state_d     = EVAL;
        end
      end
      EVAL: begin
        prob_d[idx_q] = w_num;
        mask_d[idx_q] = (w_num != '0);
        // Strict compare keeps the lower type code on ties.
        if (w_num > best_prob_q) begin
          best_type_d = idx_q;
          best_prob_d = w_num;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          none_d  = (mask_d == 4'd0);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kp_q        <= 2'd0;
      ch_q        <= 2'd0;
      idx_q       <= 2'd0;
      mask_q      <= 4'd0;
      prob_q      <= '0;
      best_type_q <= 2'd0;
      best_prob_q <= '0;
      none_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kp_q        <= kp_d;
      ch_q        <= ch_d;
      idx_q       <= idx_d;
      mask_q      <= mask_d;
      prob_q      <= prob_d;
      best_type_q <= best_type_d;
      best_prob_q <= best_prob_d;
      none_q      <= none_d;
    end
  end

  assign busy      = (state_q == EVAL);
  assign done      = (state_q == DONE);
  assign cand_mask = mask_q;
  assign prob_o    = prob_q[0];
  assign prob_b    = prob_q[1];
  assign prob_a    = prob_q[2];
  assign prob_ab   = prob_q[3];
  assign best_type = best_type_q;
  assign best_prob = best_prob_q;
  assign none      = none_q;

endmodule

`default_nettype wire
